// File: rtl/bluemax_platform_irq_ctrl.sv
// rtl/bluemax_platform_irq_ctrl.sv - memory-mapped interrupt concentrator with priority vector
//
// Collects N_IRQ (1..15) interrupt lines. Each line works in level mode or edge mode.
// Edge-mode events are latched in PENDING. The lines are gated by MASK. The block drives
// one registered irq to the CPU.
//
// Optional feature macro: BLUEMAX_IRQ_CTRL_SYNC_EN
//   defined   - irq_in passes through a 2-flop synchronizer (adds 2 clocks of latency)
//   undefined - irq_in is used directly and must be synchronous to clk
//
// Ports:
//   clk         in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   address     in   [2:0] register word address
//   chipselect  in   slave select
//   write_n     in   active-low write strobe (write = chipselect & ~write_n)
//   writedata   in   [15:0] write data
//   irq_in      in   [N_IRQ-1:0] interrupt requests, bit 0 highest priority
//   readdata    out  [15:0] registered read data (address sampled every clock)
//   irq         out  registered interrupt to the CPU
//
// Register map: 0 PENDING (R/W1C), 1 MASK (RW), 2 EDGE (RW), 3 VECTOR (R), 4 RAW (R), 5..7 read 0

module bluemax_platform_irq_ctrl #(
  parameter int N_IRQ = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [15:0]      writedata,
  input  logic [N_IRQ-1:0] irq_in,
  output logic [15:0]      readdata,
  output logic             irq
);

  logic [N_IRQ-1:0] r_pending;
  logic [N_IRQ-1:0] r_mask;
  logic [N_IRQ-1:0] r_edge;
  logic [N_IRQ-1:0] r_in_d;

  logic [N_IRQ-1:0] w_in_s;
  logic [N_IRQ-1:0] w_act;
  logic [N_IRQ-1:0] w_set;
  logic [N_IRQ-1:0] w_clr;
  logic [N_IRQ-1:0] w_edge_on;
  logic [N_IRQ-1:0] w_pending_nxt;
  logic [N_IRQ-1:0] w_wdata;
  logic             w_wr;
  logic [15:0]      w_vector;
  logic [15:0]      w_rd_mux;

`ifdef BLUEMAX_IRQ_CTRL_SYNC_EN
  logic [N_IRQ-1:0] r_sync1;
  logic [N_IRQ-1:0] r_sync2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_in_s = r_sync2;
`else
  assign w_in_s = irq_in;
`endif

  assign w_wr    = chipselect & ~write_n;
  assign w_wdata = writedata[N_IRQ-1:0];
  assign w_set   = w_in_s & ~r_in_d;
  assign w_clr   = (w_wr && address == 3'd0) ? w_wdata : '0;
  // Lines moving from level to edge mode start with an empty latch.
  assign w_edge_on = (w_wr && address == 3'd2) ? (w_wdata & ~r_edge) : '0;

  // Edge bits: set has priority over W1C. Level bits: track the input and ignore W1C.
  assign w_pending_nxt = ((r_edge & (w_set | (r_pending & ~w_clr))) | (~r_edge & w_in_s))
                         & ~w_edge_on;

  assign w_act = r_pending & r_mask;

  // Scan from the top down so that the lowest set index is the one left in w_vector.
  always_comb begin
    w_vector = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (w_act[i]) begin
        w_vector = 16'h8000 | 16'(i);
      end
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (address)
      3'd0:    w_rd_mux = 16'(r_pending);
      3'd1:    w_rd_mux = 16'(r_mask);
      3'd2:    w_rd_mux = 16'(r_edge);
      3'd3:    w_rd_mux = w_vector;
      3'd4:    w_rd_mux = 16'(w_in_s);
      default: w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
      r_mask    <= '0;
      r_edge    <= '0;
      r_in_d    <= '0;
      readdata  <= '0;
      irq       <= 1'b0;
    end else begin
      r_in_d    <= w_in_s;
      r_pending <= w_pending_nxt;
      irq       <= |w_act;
      readdata  <= w_rd_mux;
      if (w_wr && address == 3'd1) begin
        r_mask <= w_wdata;
      end
      if (w_wr && address == 3'd2) begin
        r_edge <= w_wdata;
      end
    end
  end

endmodule
